exe_stage: RTL

Execute stage of the 5-stage 8-bit pipeline, directly downstream of the ID/EXE register. Consumes the latched control and operand bundle, resolves operand hazards through EX/MEM and MEM/WB forwarding, and runs the 8-bit ALU. Holds the architectural carry and zero flags and computes the branch target. Registers the result bundle into the EX/MEM pipeline latch for the memory stage.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/forwarding_unit.sv | 34 +++
 rtl/exe_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: widths, ALU opcodes, EX/MEM bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;
  localparam int PC_W   = 12;
  localparam int OP_W   = 4;

  // Opcodes 13..15 all behave as PASS_A; only 13 is named.
  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_ADC    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_SBC    = 4'd3,
    ALU_AND    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_MASK   = 4'd7,
    ALU_SHL    = 4'd8,
    ALU_SHR    = 4'd9,
    ALU_ROL    = 4'd10,
    ALU_ROR    = 4'd11,
    ALU_PASS_B = 4'd12,
    ALU_PASS_A = 4'd13
  } alu_op_e;

  // EX/MEM pipeline latch contents.
  typedef struct packed {
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
  } exmem_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass select for one source register: EX/MEM, then MEM/WB, then ID/EXE value.
// Latency: combinational, 0 cycles.
// Backpressure: none; load-use hazards are stalled upstream by the hazard unit.
// Ports: src (register index), id_val (ID/EXE operand), ex_* (EX/MEM latch),
//        wb_* (MEM/WB writeback), fwd_val (selected operand).
module forwarding_unit
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] id_val,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_rd,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_reg_wr,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_val
);

  // A load in EX/MEM has no data yet (aluResult is the address), so it never bypasses.
  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_reg_wr && !ex_mem_rd && (ex_rd == src);
  assign wb_hit = wb_reg_wr && (wb_rd == src);

  always_comb begin
    fwd_val = id_val;
    if (ex_hit)      fwd_val = ex_data;
    else if (wb_hit) fwd_val = wb_data;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, 8-bit ALU, C/Z flags, branch target, EX/MEM latch.
// Latency: 1 cycle to EX/MEM outputs and flags; brTarget_OUT is combinational.
// Backpressure: stall holds latch and flags; flush inserts a bubble (overrides stall); rst overrides both.
// Ports: clk/rst/stall/flush; ID/EXE control+operands (*_IN); MEM/WB forwarding source (wb*_IN);
//        EX/MEM bundle, flags and brTarget_OUT.
// Build option: define EXE_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module exe_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              regWr_IN,
  input  logic              memRd_IN,
  input  logic              memWr_IN,
  input  logic              cWr_IN,
  input  logic              zWr_IN,
  input  logic              useImm_IN,
  input  logic [OP_W-1:0]   aluOp_IN,
  input  logic [REG_W-1:0]  rd_IN,
  input  logic [REG_W-1:0]  rs_IN,
  input  logic [REG_W-1:0]  rt_IN,
  input  logic [DATA_W-1:0] regData1_IN,
  input  logic [DATA_W-1:0] regData2_IN,
  input  logic [DATA_W-1:0] immConst_IN,
  input  logic [DATA_W-1:0] brDisp_IN,
  input  logic [PC_W-1:0]   pcPlus1_IN,
  input  logic              wbRegWr_IN,
  input  logic [REG_W-1:0]  wbRd_IN,
  input  logic [DATA_W-1:0] wbData_IN,
  output logic              regWr_OUT,
  output logic              memRd_OUT,
  output logic              memWr_OUT,
  output logic [REG_W-1:0]  rd_OUT,
  output logic [DATA_W-1:0] aluResult_OUT,
  output logic [DATA_W-1:0] storeData_OUT,
  output logic              c_OUT,
  output logic              z_OUT,
  output logic [PC_W-1:0]   brTarget_OUT
);

  exmem_t            ex_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] op_b;

`ifdef EXE_FWD_EN
  forwarding_unit u_fwd_rs (
    .src       (rs_IN),
    .id_val    (regData1_IN),
    .ex_reg_wr (ex_q.reg_wr),
    .ex_mem_rd (ex_q.mem_rd),
    .ex_rd     (ex_q.rd),
    .ex_data   (ex_q.alu_result),
    .wb_reg_wr (wbRegWr_IN),
    .wb_rd     (wbRd_IN),
    .wb_data   (wbData_IN),
    .fwd_val   (op_a)
  );

  forwarding_unit u_fwd_rt (
    .src       (rt_IN),
    .id_val    (regData2_IN),
    .ex_reg_wr (ex_q.reg_wr),
    .ex_mem_rd (ex_q.mem_rd),
    .ex_rd     (ex_q.rd),
    .ex_data   (ex_q.alu_result),
    .wb_reg_wr (wbRegWr_IN),
    .wb_rd     (wbRd_IN),
    .wb_data   (wbData_IN),
    .fwd_val   (rt_val)
  );
`else
  // Without bypassing, spacing is guaranteed upstream; the indices and WB port go unused.
  logic unused_fwd;
  assign unused_fwd = ^{rs_IN, rt_IN, wbRegWr_IN, wbRd_IN, wbData_IN};
  assign op_a   = regData1_IN;
  assign rt_val = regData2_IN;
`endif

  // Store data is always the register value, never the immediate.
  assign op_b = useImm_IN ? immConst_IN : rt_val;

  alu_op_e           op;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              c_new;
  logic              z_new;

  assign op = alu_op_e'(aluOp_IN);

  // For SUB/SBC the 9-bit difference wraps, so bit 8 is exactly the unsigned borrow.
  always_comb begin
    sum   = '0;
    res   = op_a;
    c_new = 1'b0;
    case (op)
      ALU_ADD:    begin sum = {1'b0, op_a} + {1'b0, op_b};                   res = sum[7:0]; c_new = sum[8]; end
      ALU_ADC:    begin sum = {1'b0, op_a} + {1'b0, op_b} + {8'd0, c_OUT};   res = sum[7:0]; c_new = sum[8]; end
      ALU_SUB:    begin sum = {1'b0, op_a} - {1'b0, op_b};                   res = sum[7:0]; c_new = sum[8]; end
      ALU_SBC:    begin sum = {1'b0, op_a} - {1'b0, op_b} - {8'd0, c_OUT};   res = sum[7:0]; c_new = sum[8]; end
      ALU_AND:    res = op_a & op_b;
      ALU_OR:     res = op_a | op_b;
      ALU_XOR:    res = op_a ^ op_b;
      ALU_MASK:   res = op_a & ~op_b;
      ALU_SHL:    begin res = {op_a[6:0], 1'b0};    c_new = op_a[7]; end
      ALU_SHR:    begin res = {1'b0, op_a[7:1]};    c_new = op_a[0]; end
      ALU_ROL:    begin res = {op_a[6:0], op_a[7]}; c_new = op_a[7]; end
      ALU_ROR:    begin res = {op_a[0], op_a[7:1]}; c_new = op_a[0]; end
      ALU_PASS_B: res = op_b;
      default:    res = op_a;
    endcase
  end

  assign z_new = (res == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      c_OUT <= 1'b0;
      z_OUT <= 1'b0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q.reg_wr     <= regWr_IN;
      ex_q.mem_rd     <= memRd_IN;
      ex_q.mem_wr     <= memWr_IN;
      ex_q.rd         <= rd_IN;
      ex_q.alu_result <= res;
      ex_q.store_data <= rt_val;
      if (cWr_IN) c_OUT <= c_new;
      if (zWr_IN) z_OUT <= z_new;
    end
  end

  assign regWr_OUT     = ex_q.reg_wr;
  assign memRd_OUT     = ex_q.mem_rd;
  assign memWr_OUT     = ex_q.mem_wr;
  assign rd_OUT        = ex_q.rd;
  assign aluResult_OUT = ex_q.alu_result;
  assign storeData_OUT = ex_q.store_data;

  assign brTarget_OUT = pcPlus1_IN + {{(PC_W-DATA_W){brDisp_IN[DATA_W-1]}}, brDisp_IN};

endmodule
